axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master.sv | 215 +++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI3/4 burst master bridging 16-bit stream ports to 64-bit INCR bursts.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_burst_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [15:0]       src_data,
  output logic              snk_valid,
  input  logic              snk_ready,
  output logic [15:0]       snk_data,
  output logic              done,
  output logic              err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic              rlast,
  input  logic [1:0]        rresp
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAw   = 3'd1;
  localparam logic [2:0] StW    = 3'd2;
  localparam logic [2:0] StB    = 3'd3;
  localparam logic [2:0] StAr   = 3'd4;
  localparam logic [2:0] StR    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              last_beat;
  logic              r_beat_err;

  // Only the low 16 bits of each read beat carry a sample.
  logic unused_rdata;
  assign unused_rdata = ^rdata[63:16];

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;
  logic            any_hs;
  assign tmo_hit = (state_q != StIdle) && (tmo_q == TmoW'(TIMEOUT - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT;
`endif

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    r_beat_err = 1'b0;
    cmd_ready  = 1'b0;
    src_ready  = 1'b0;
    snk_valid  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awaddr     = addr_q;
    araddr     = addr_q;
    awlen      = len_q;
    arlen      = len_q;
    awsize     = 3'b001;
    arsize     = 3'b001;
    awburst    = 2'b01;
    arburst    = 2'b01;
    wdata      = {48'h0, src_data};
    wstrb      = 8'h03;
    snk_data   = rdata[15:0];

    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = cmd_write ? StAw : StAr;
        end
      end
      StAw: begin
        awvalid = 1'b1;
        if (awready) begin
          cnt_d   = 4'd0;
          state_d = StW;
        end
      end
      StW: begin
        wvalid    = src_valid;
        src_ready = wready;
        wlast     = last_beat;
        if (src_valid && wready) begin
          if (last_beat) state_d = StB;
          else           cnt_d   = cnt_q + 4'd1;
        end
      end
      StB: begin
        bready = 1'b1;
        if (bvalid) begin
          done    = 1'b1;
          err     = (bresp != 2'b00);
          state_d = StIdle;
        end
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) begin
          cnt_d   = 4'd0;
          state_d = StR;
        end
      end
      StR: begin
        rready    = snk_ready;
        snk_valid = rvalid;
        if (rvalid && snk_ready) begin
          // A misplaced or missing rlast is treated as a protocol error.
          r_beat_err = (rresp != 2'b00) || (rlast && !last_beat) || (!rlast && last_beat);
          err_d      = err_q | r_beat_err;
          if (last_beat) begin
            done    = 1'b1;
            err     = err_d;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    any_hs = (awvalid && awready) || (wvalid && wready) || (bvalid && bready) ||
             (arvalid && arready) || (rvalid && rready);
    tmo_d  = (state_q == StIdle || any_hs) ? '0 : tmo_q + 1'b1;
    if (tmo_hit) begin
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      src_ready = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      snk_valid = 1'b0;
      done      = 1'b1;
      err       = 1'b1;
      tmo_d     = '0;
      state_d   = StIdle;
    end
`endif
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed self-checking bench for axi_burst_master; the bench plays the AXI slave.
module tb_axi_burst_master;

  logic        a_clk = 1'b0;
  logic        a_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        src_valid, src_ready;
  logic [15:0] src_data;
  logic        snk_valid, snk_ready;
  logic [15:0] snk_data;
  logic        done, err;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic        rlast;
  logic [1:0]  rresp;

  int checks = 0;
  int failures = 0;
  logic [15:0] buf_q [16];

  always #5 a_clk = ~a_clk;

  axi_burst_master #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .done(done), .err(err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp)
  );

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    src_valid = 0; src_data = 0; snk_ready = 0; awready = 0; wready = 0;
    bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0;
    repeat (3) tick();
    a_rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, src_ready, snk_valid, done, err} !== 9'h0)
    begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0",
               {awvalid, wvalid, bready, arvalid, rready, src_ready, snk_valid, done, err});
    end
  endtask

  task automatic run_write(input string name, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] resp, input logic exp_err);
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len; awready = 1; wready = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL %s_cmd_ready: got %b want 1", name, cmd_ready);
    end
    tick();
    cmd_valid = 0;
    #1;
    checks++;
    if ({awvalid, awaddr, awlen, awsize, awburst} !== {1'b1, addr, len, 3'b001, 2'b01}) begin
      failures++;
      $display("FAIL %s_aw: got v=%b a=%h l=%0d s=%b b=%b want v=1 a=%h l=%0d s=001 b=01",
               name, awvalid, awaddr, awlen, awsize, awburst, addr, len);
    end
    for (int b = 0; b <= int'(len); b++) begin
      tick();
      awready = 0; src_valid = 1; src_data = buf_q[b];
      #1;
      checks++;
      if ({wvalid, src_ready, wdata, wstrb, wlast} !==
          {1'b1, 1'b1, 48'h0, buf_q[b], 8'h03, (b == int'(len))}) begin
        failures++;
        $display("FAIL %s_w%0d: got v=%b r=%b d=%h s=%h l=%b want d=%h l=%b", name, b, wvalid,
                 src_ready, wdata, wstrb, wlast, buf_q[b], (b == int'(len)));
      end
    end
    tick();
    src_valid = 0;
    #1;
    checks++;
    if ({bready, wvalid, done, cmd_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL %s_b_wait: got br/wv/done/cr=%b want 1000",
               name, {bready, wvalid, done, cmd_ready});
    end
    tick();
    bvalid = 1; bresp = resp;
    #1;
    checks++;
    if ({done, err, cmd_ready} !== {1'b1, exp_err, 1'b0}) begin
      failures++;
      $display("FAIL %s_done: got done/err/cr=%b%b%b want 1%b0", name, done, err, cmd_ready,
               exp_err);
    end
    tick();
    bvalid = 0; bresp = 0;
    #1;
    checks++;
    if ({done, cmd_ready} !== 2'b01) begin
      failures++; $display("FAIL %s_idle: got done/cr=%b%b want 01", name, done, cmd_ready);
    end
  endtask

  task automatic run_read(input string name, input logic [31:0] addr, input logic [3:0] len,
                          input int rlast_at, input bit toggle, input logic exp_err);
    int  k = 0;
    bit  ph = 1'b1;
    tick();
    cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len; arready = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL %s_cmd_ready: got %b want 1", name, cmd_ready);
    end
    tick();
    cmd_valid = 0;
    #1;
    checks++;
    if ({arvalid, araddr, arlen, arsize, arburst} !== {1'b1, addr, len, 3'b001, 2'b01}) begin
      failures++;
      $display("FAIL %s_ar: got v=%b a=%h l=%0d s=%b b=%b want a=%h l=%0d",
               name, arvalid, araddr, arlen, arsize, arburst, addr, len);
    end
    for (int cyc = 0; cyc < 64 && k <= int'(len); cyc++) begin
      tick();
      arready = 0; rvalid = 1; rdata = {48'h0123_4567_89AB, buf_q[k]};
      rlast = (k == rlast_at); rresp = 0;
      snk_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      #1;
      checks++;
      if ({snk_valid, rready, snk_data} !== {1'b1, snk_ready, buf_q[k]}) begin
        failures++;
        $display("FAIL %s_r%0d: got sv=%b rr=%b d=%h want sv=1 rr=%b d=%h", name, k, snk_valid,
                 rready, snk_data, snk_ready, buf_q[k]);
      end
      checks++;
      if (done !== (snk_ready && k == int'(len))) begin
        failures++;
        $display("FAIL %s_done_r%0d: got %b want %b", name, k, done, (snk_ready && k == int'(len)));
      end
      if (snk_ready) begin
        if (k == int'(len)) begin
          checks++;
          if (err !== exp_err) begin
            failures++; $display("FAIL %s_err: got %b want %b", name, err, exp_err);
          end
        end
        k++;
      end
    end
    checks++;
    if (k != int'(len) + 1) begin
      failures++; $display("FAIL %s_beats: got %0d want %0d", name, k, int'(len) + 1);
    end
    tick();
    rvalid = 0; rlast = 0; snk_ready = 0;
    #1;
    checks++;
    if ({done, cmd_ready} !== 2'b01) begin
      failures++; $display("FAIL %s_idle: got done/cr=%b%b want 01", name, done, cmd_ready);
    end
  endtask

  task automatic test_write_read();
    buf_q[0] = 16'hABCD; buf_q[1] = 16'hFDDF; buf_q[2] = 16'hFAFA;
    run_write("wr3", 32'h0A, 4'd2, 2'b00, 1'b0);
    run_read("rd3", 32'h0A, 4'd2, 2, 1'b1, 1'b0);
  endtask

  task automatic test_len0();
    buf_q[0] = 16'h1234;
    run_write("wr_len0", 32'h40, 4'd0, 2'b00, 1'b0);
  endtask

  task automatic test_errors();
    buf_q[0] = 16'h1111; buf_q[1] = 16'h2222; buf_q[2] = 16'h3333;
    run_read("rd_early_rlast", 32'h80, 4'd2, 1, 1'b0, 1'b1);
    run_write("wr_slverr", 32'h90, 4'd1, 2'b10, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_len = 4'd3; awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    tick();
    awready = 0; src_valid = 1; src_data = 16'h5555;
    tick();
    src_data = 16'h6666; a_rst = 1;
    tick();
    a_rst = 0; src_valid = 0; bvalid = 1;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, src_ready, snk_valid, done} !== 8'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %b want 0",
               {awvalid, wvalid, bready, arvalid, rready, src_ready, snk_valid, done});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_cmd_ready: got %b want 1", cmd_ready);
    end
    tick();
    bvalid = 0;
    #1;
    checks++;
    if ({done, cmd_ready} !== 2'b01) begin
      failures++; $display("FAIL rst_mid_after: got done/cr=%b%b want 01", done, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    int seen = -1;
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hC0; cmd_len = 4'd0; awready = 0;
    tick();
    cmd_valid = 0;
    for (int cyc = 0; cyc < 40 && seen < 0; cyc++) begin
      #1;
      if (done) seen = cyc;
      else tick();
    end
`ifdef AXI_MASTER_TIMEOUT_EN
    checks++;
    if (seen != 15) begin
      failures++; $display("FAIL tmo_cycle: got %0d want 15", seen);
    end
    checks++;
    if ({err, awvalid} !== 2'b10) begin
      failures++; $display("FAIL tmo_err: got err/awv=%b%b want 10", err, awvalid);
    end
    tick();
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL tmo_idle: got %b want 1", cmd_ready);
    end
`else
    checks++;
    if (seen != -1 || awvalid !== 1'b1) begin
      failures++; $display("FAIL no_tmo_wait: got done_at=%0d awv=%b want -1 1", seen, awvalid);
    end
    // Clear the stuck write so the block is left idle.
    a_rst = 1;
    tick();
    a_rst = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_len0();
    test_errors();
    test_reset_mid_burst();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
